// File: rtl/pipe_stage_if.sv
// Signal bundle for one inter-stage pipeline register.
// The master side (the upstream stage, or a bench) drives the controls and
// in_* fields, and reads the out_* fields.
// The slave side is the register itself.
interface pipe_stage_if #(
  parameter int VAL_N  = 2,
  parameter int DW     = 32,
  parameter int TNEW_W = 2
);
  logic                 en;
  logic                 stall_bubble;
  logic                 flush;
  logic [VAL_N*DW-1:0]  in_val;
  logic [DW-1:0]        in_ext;
  logic [DW-1:0]        in_pc;
  logic [DW-1:0]        in_instr;
  logic [4:0]           in_a3;
  logic [4:0]           in_exc;
  logic                 in_bd;
  logic [TNEW_W-1:0]    in_tnew;
  logic                 in_valid;
  logic [VAL_N*DW-1:0]  out_val;
  logic [DW-1:0]        out_ext;
  logic [DW-1:0]        out_pc;
  logic [DW-1:0]        out_instr;
  logic [4:0]           out_a3;
  logic [4:0]           out_exc;
  logic                 out_bd;
  logic [TNEW_W-1:0]    out_tnew;
  logic                 out_valid;
  logic [TNEW_W-1:0]    out_tnew_fwd;

  modport master (
    output en, stall_bubble, flush, in_val, in_ext, in_pc, in_instr,
           in_a3, in_exc, in_bd, in_tnew, in_valid,
    input  out_val, out_ext, out_pc, out_instr, out_a3, out_exc, out_bd,
           out_tnew, out_valid, out_tnew_fwd
  );

  modport slave (
    input  en, stall_bubble, flush, in_val, in_ext, in_pc, in_instr,
           in_a3, in_exc, in_bd, in_tnew, in_valid,
    output out_val, out_ext, out_pc, out_instr, out_a3, out_exc, out_bd,
           out_tnew, out_valid, out_tnew_fwd
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the five-stage MIPS core.
// It carries VAL_N operand lanes plus PC, instruction, destination register,
// exception code, branch-delay flag and the Tnew hazard counter.
// It also exports the saturating decrement of Tnew for the next stage's
// hazard unit.
// Edge priority: flush > stall_bubble > en > hold. The async reset is above all.
// Optional macro STAGE_KEEP_PC_EN: a bubble keeps in_pc/in_bd, so that an
// interrupt taken on the bubble reports the right EPC/BD.
// Without the macro, a bubble resets PC/BD the same way a flush does.
module pipe_stage_reg #(
  parameter int          VAL_N   = 2,
  parameter int          DW      = 32,
  parameter int          TNEW_W  = 2,
  parameter logic [31:0] INIT_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  pipe_stage_if.slave  bus
);

  localparam logic [DW-1:0] PC_RST = DW'(INIT_PC);

  logic [VAL_N*DW-1:0] val_q,   val_d;
  logic [DW-1:0]       ext_q,   ext_d;
  logic [DW-1:0]       pc_q,    pc_d;
  logic [DW-1:0]       instr_q, instr_d;
  logic [4:0]          a3_q,    a3_d;
  logic [4:0]          exc_q,   exc_d;
  logic                bd_q,    bd_d;
  logic [TNEW_W-1:0]   tnew_q,  tnew_d;
  logic                valid_q, valid_d;

  // Next-state selection: hold by default, then apply the prioritised actions.
  always_comb begin
    val_d   = val_q;
    ext_d   = ext_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    a3_d    = a3_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    tnew_d  = tnew_q;
    valid_d = valid_q;
    if (bus.flush) begin
      val_d   = '0;
      ext_d   = '0;
      pc_d    = PC_RST;
      instr_d = '0;
      a3_d    = '0;
      exc_d   = '0;
      bd_d    = 1'b0;
      tnew_d  = '0;
      valid_d = 1'b0;
    end else if (bus.stall_bubble) begin
      val_d   = '0;
      ext_d   = '0;
      instr_d = '0;
      a3_d    = '0;
      exc_d   = '0;
      tnew_d  = '0;
      valid_d = 1'b0;
`ifdef STAGE_KEEP_PC_EN
      pc_d    = bus.in_pc;
      bd_d    = bus.in_bd;
`else
      pc_d    = PC_RST;
      bd_d    = 1'b0;
`endif
    end else if (bus.en) begin
      val_d   = bus.in_val;
      ext_d   = bus.in_ext;
      pc_d    = bus.in_pc;
      instr_d = bus.in_instr;
      exc_d   = bus.in_exc;
      bd_d    = bus.in_bd;
      valid_d = bus.in_valid;
      // An empty slot must never look like a pending register write to the hazard unit.
      a3_d    = bus.in_valid ? bus.in_a3   : 5'd0;
      tnew_d  = bus.in_valid ? bus.in_tnew : '0;
    end
  end

  // Stage state register; reset clears it immediately, without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      ext_q   <= '0;
      pc_q    <= PC_RST;
      instr_q <= '0;
      a3_q    <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      tnew_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      ext_q   <= ext_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      a3_q    <= a3_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_val   = val_q;
  assign bus.out_ext   = ext_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_a3    = a3_q;
  assign bus.out_exc   = exc_q;
  assign bus.out_bd    = bd_q;
  assign bus.out_tnew  = tnew_q;
  assign bus.out_valid = valid_q;

  // The forwarded Tnew stops at zero, so it never wraps to all-ones.
  assign bus.out_tnew_fwd = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);

endmodule
